// File: rtl/led_band_pkg.sv
// Shared constants and state type for the LED band cylinder memory, its writer,
// the angle tracker and the column reader.
package led_band_pkg;

    localparam int R_ADDR_WIDTH = 15;
    localparam int R_DATA_WIDTH = 8;
    localparam int COL_BYTES    = 48;
    localparam int N_COLS       = 288;
    localparam int COL_W        = 9;
    localparam int BYTE_CNT_W   = $clog2(COL_BYTES);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} col_rd_state_t;

    // First byte address of a column; 287*48+47 fits R_ADDR_WIDTH, so no overflow.
    function automatic logic [R_ADDR_WIDTH-1:0] col_base(input logic [COL_W-1:0] idx);
        return R_ADDR_WIDTH'(idx) * R_ADDR_WIDTH'(COL_BYTES);
    endfunction

endpackage

// File: rtl/led_shift_out.sv
// Byte serialiser: holding register, MSB-first shift register and a two-phase
// sclk generator (phase0 presents sdo, phase1 raises sclk).
module led_shift_out
    import led_band_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_shift_en,
    input  logic                    i_last,
    input  logic [R_DATA_WIDTH-1:0] i_byte,
    output logic                    o_sdo,
    output logic                    o_sclk,
    output logic                    o_byte_done,
    output logic                    o_prefetch_req
);

    localparam int BIT_W = $clog2(R_DATA_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(R_DATA_WIDTH - 1);

    logic [R_DATA_WIDTH-1:0] r_shift;
    logic [R_DATA_WIDTH-1:0] r_hold;
    logic [BIT_W-1:0]        r_bit;
    logic                    r_phase;
    logic                    r_sdo;
    logic                    r_sclk;
    logic                    r_hold_we;

    // Next byte is requested while its predecessor's second bit is on the pins.
    assign o_prefetch_req = i_shift_en && !r_phase && (r_bit == BIT_W'(1)) && !i_last;
    assign o_byte_done    = i_shift_en && r_phase && (r_bit == LAST_BIT);
    assign o_sdo          = r_sdo;
    assign o_sclk         = r_sclk;

    // NOTE: every register uses <= so all of them sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_hold    <= '0;
            r_bit     <= '0;
            r_phase   <= 1'b0;
            r_sdo     <= 1'b0;
            r_sclk    <= 1'b0;
            r_hold_we <= 1'b0;
        end else begin
            r_hold_we <= o_prefetch_req;
            if (r_hold_we) begin
                r_hold <= i_byte;
            end
            if (i_load) begin
                r_shift <= i_byte;
                r_sdo   <= i_byte[R_DATA_WIDTH-1];
                r_sclk  <= 1'b0;
                r_phase <= 1'b0;
                r_bit   <= '0;
            end else if (i_shift_en) begin
                if (!r_phase) begin
                    r_sclk  <= 1'b1;
                    r_phase <= 1'b1;
                end else begin
                    r_sclk  <= 1'b0;
                    r_phase <= 1'b0;
                    if (r_bit == LAST_BIT) begin
                        r_bit   <= '0;
                        r_shift <= r_hold;
                        r_sdo   <= i_last ? 1'b0 : r_hold[R_DATA_WIDTH-1];
                    end else begin
                        r_bit   <= r_bit + BIT_W'(1);
                        r_shift <= {r_shift[R_DATA_WIDTH-2:0], 1'b0};
                        r_sdo   <= r_shift[R_DATA_WIDTH-2];
                    end
                end
            end else begin
                r_sdo   <= 1'b0;
                r_sclk  <= 1'b0;
                r_phase <= 1'b0;
                r_bit   <= '0;
            end
        end
    end

endmodule

// File: rtl/led_column_reader.sv
// Column reader: on col_start fetches one column from the cylinder memory and
// streams it to the LED drivers, then pulses lat.
module led_column_reader
    import led_band_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    col_start,
    input  logic [COL_W-1:0]        col_idx,
    output logic                    read,
    output logic [R_ADDR_WIDTH-1:0] r_addr,
    input  logic [R_DATA_WIDTH-1:0] r_data,
    output logic                    sdo,
    output logic                    sclk,
    output logic                    lat,
    output logic                    busy,
    output logic                    err
);

    col_rd_state_t           r_state;
    col_rd_state_t           w_next;
    logic [R_ADDR_WIDTH-1:0] r_base;
    logic [R_ADDR_WIDTH-1:0] r_addr_q;
    logic [R_ADDR_WIDTH-1:0] w_addr;
    logic [BYTE_CNT_W-1:0]   r_byte_cnt;
    logic                    r_lat;
    logic                    w_idx_ok;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_shift_en;
    logic                    w_last;
    logic                    w_byte_done;
    logic                    w_prefetch;

    assign w_idx_ok = col_idx < COL_W'(N_COLS);
    assign w_accept = !rst && col_start && (r_state == IDLE) && w_idx_ok;
    assign w_last   = r_byte_cnt == BYTE_CNT_W'(COL_BYTES - 1);

    // The first byte is requested in the accept cycle so the memory latency hides in FETCH.
    assign w_addr = w_accept   ? col_base(col_idx) :
                    w_prefetch ? r_base + R_ADDR_WIDTH'(r_byte_cnt) + R_ADDR_WIDTH'(1) :
                                 r_addr_q;

    assign read   = w_accept || w_prefetch;
    assign r_addr = w_addr;
    assign busy   = (r_state != IDLE);
    assign err    = !rst && col_start && ((r_state != IDLE) || !w_idx_ok);
    assign lat    = r_lat;

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_shift_en = 1'b0;
        case (r_state)
            IDLE:  if (w_accept) w_next = FETCH;
            FETCH: begin
                w_load = 1'b1;
                w_next = SHIFT;
            end
            SHIFT: begin
                w_shift_en = 1'b1;
                if (w_byte_done && w_last) w_next = LATCH;
            end
            LATCH: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_addr_q   <= '0;
            r_byte_cnt <= '0;
            r_lat      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_lat   <= (w_next == LATCH);
            if (read) begin
                r_addr_q <= w_addr;
            end
            if (w_accept) begin
                r_base <= col_base(col_idx);
            end
            if (r_state == IDLE) begin
                r_byte_cnt <= '0;
            end else if (w_byte_done && !w_last) begin
                r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
            end
        end
    end

    led_shift_out u_shift_out (
        .clk            (clk),
        .rst            (rst),
        .i_load         (w_load),
        .i_shift_en     (w_shift_en),
        .i_last         (w_last),
        .i_byte         (r_data),
        .o_sdo          (sdo),
        .o_sclk         (sclk),
        .o_byte_done    (w_byte_done),
        .o_prefetch_req (w_prefetch)
    );

endmodule

// File: tb/tb_led_column_reader.sv
// Scoreboard bench for led_column_reader: stimulus pushes expected reads, bits,
// latches and errors; a negedge monitor pops and compares as the DUT presents them.
module tb_led_column_reader;
    import led_band_pkg::*;

    typedef struct {
        int                      cyc;
        logic [R_ADDR_WIDTH-1:0] addr;
    } exp_rd_t;

    typedef struct {
        int   cyc;
        logic b;
    } exp_bit_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    col_start = 1'b0;
    logic [COL_W-1:0]        col_idx = '0;
    logic                    read;
    logic [R_ADDR_WIDTH-1:0] r_addr;
    logic [R_DATA_WIDTH-1:0] r_data = '0;
    logic                    sdo;
    logic                    sclk;
    logic                    lat;
    logic                    busy;
    logic                    err;

    exp_rd_t  q_rd[$];
    exp_bit_t q_bit[$];
    int       q_lat[$];
    int       q_err[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat_count = 0;
    int read_count = 0;
    int rise_count = 0;
    logic [R_ADDR_WIDTH-1:0] first_addr = '0;
    logic [R_ADDR_WIDTH-1:0] last_rd_addr = '0;
    logic prev_sclk = 1'b0;
    logic lat_prev = 1'b0;

    always #5 clk = ~clk;

    led_column_reader dut (
        .clk       (clk),
        .rst       (rst),
        .col_start (col_start),
        .col_idx   (col_idx),
        .read      (read),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .sdo       (sdo),
        .sclk      (sclk),
        .lat       (lat),
        .busy      (busy),
        .err       (err)
    );

    // Memory model: one-cycle latency, byte[a] = a[7:0] ^ 8'hA5.
    always @(posedge clk) begin
        if (read) r_data <= r_addr[7:0] ^ 8'hA5;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_sclk = 1'b0;
            lat_prev  = 1'b0;
        end else begin
            if (read) begin
                read_count++;
                last_rd_addr = r_addr;
                check("read_expected", q_rd.size() != 0, 1);
                if (q_rd.size() != 0) begin
                    exp_rd_t e;
                    e = q_rd.pop_front();
                    check("r_addr", r_addr, e.addr);
                    check("read_cyc", cyc, e.cyc);
                end
            end
            if (sclk && !prev_sclk) begin
                rise_count++;
                check("bit_expected", q_bit.size() != 0, 1);
                if (q_bit.size() != 0) begin
                    exp_bit_t eb;
                    eb = q_bit.pop_front();
                    check("sdo", sdo, eb.b);
                    check("sclk_rise_cyc", cyc, eb.cyc);
                end
            end
            prev_sclk = sclk;
            if (lat_prev) check("busy_after_lat", busy, 0);
            if (lat) begin
                lat_count++;
                check("lat_expected", q_lat.size() != 0, 1);
                if (q_lat.size() != 0) check("lat_cyc", cyc, q_lat.pop_front());
            end
            lat_prev = lat;
            if (err) begin
                check("err_expected", q_err.size() != 0, 1);
                if (q_err.size() != 0) check("err_cyc", cyc, q_err.pop_front());
            end
        end
    end

    // Called at posedge+1; issues col_start for one cycle and returns at posedge+1 of cycle 1.
    task automatic start_col(input int idx);
        int s;
        s = cyc;
        col_start = 1'b1;
        col_idx   = COL_W'(idx);
        for (int k = 0; k < COL_BYTES; k++) begin
            logic [R_ADDR_WIDTH-1:0] a;
            logic [7:0]              bv;
            a  = R_ADDR_WIDTH'(idx * COL_BYTES + k);
            bv = a[7:0] ^ 8'hA5;
            q_rd.push_back('{cyc: (k == 0) ? s : s + 16 * k - 12, addr: a});
            for (int b = 7; b >= 0; b--) begin
                q_bit.push_back('{cyc: s + 3 + 2 * (8 * k + (7 - b)), b: bv[b]});
            end
        end
        q_lat.push_back(s + 770);
        #2;
        first_addr = r_addr;
        @(posedge clk);
        #1;
        col_start = 1'b0;
    endtask

    task automatic wait_lat(input int n0);
        int t;
        t = 0;
        while (lat_count == n0 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("lat_seen_in_budget", lat_count != n0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read"},   read,   0);
        check({tag, "_r_addr"}, r_addr, 0);
        check({tag, "_sdo"},    sdo,    0);
        check({tag, "_sclk"},   sclk,   0);
        check({tag, "_lat"},    lat,    0);
        check({tag, "_busy"},   busy,   0);
        check({tag, "_err"},    err,    0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int rd0;
        int rs0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: column 0
        n0 = lat_count; rd0 = read_count;
        start_col(0);
        check("col0_first_addr", first_addr, 0);
        check("col0_busy_cycle1", busy, 1);
        wait_lat(n0);
        check("col0_reads", read_count - rd0, 48);

        // 2: last column
        n0 = lat_count; rd0 = read_count; rs0 = rise_count;
        start_col(287);
        check("col287_first_addr", first_addr, 13776);
        wait_lat(n0);
        check("col287_last_addr", last_rd_addr, 13823);
        check("col287_rises", rise_count - rs0, 384);
        check("col287_lats", lat_count - n0, 1);
        check("col287_reads", read_count - rd0, 48);

        // 3: out-of-range column
        rd0 = read_count;
        col_start = 1'b1;
        col_idx   = COL_W'(288);
        q_err.push_back(cyc);
        #2;
        check("bad_idx_read", read, 0);
        @(posedge clk);
        #1;
        col_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bad_idx_busy", busy, 0);
        check("bad_idx_reads", read_count - rd0, 0);

        // 4: col_start while busy
        n0 = lat_count; rd0 = read_count;
        start_col(5);
        repeat (99) @(posedge clk);
        #1;
        col_start = 1'b1;
        col_idx   = COL_W'(9);
        q_err.push_back(cyc);
        @(posedge clk);
        #1;
        col_start = 1'b0;
        wait_lat(n0);
        check("busy_reject_reads", read_count - rd0, 48);

        // 5: reset mid-column, then column 4
        n0 = lat_count;
        start_col(3);
        repeat (199) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        q_rd.delete();
        q_bit.delete();
        q_lat.delete();
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_lat", lat_count - n0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n0 = lat_count;
        start_col(4);
        check("col4_first_addr", first_addr, 192);
        wait_lat(n0);

        // 6: back-to-back in the cycle busy falls
        start_col(6);
        repeat (770) @(posedge clk);
        #1;
        check("b2b_busy_low_771", busy, 0);
        n0 = lat_count;
        start_col(7);
        check("b2b_accept_busy", busy, 1);
        wait_lat(n0);

        repeat (3) @(posedge clk);
        #1;
        check("rd_queue_drained",  q_rd.size(),  0);
        check("bit_queue_drained", q_bit.size(), 0);
        check("lat_queue_drained", q_lat.size(), 0);
        check("err_queue_drained", q_err.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
